// File: rtl/wakeup_select_queue.sv
// Issue queue with tag wakeup from the broadcast buses and oldest-ready (or strictly in-order) select.
// Age is tracked with a pairwise matrix, so slot index never implies age.
module wakeup_select_queue #(
  parameter int DEPTH     = 16,
  parameter int NUM_CDB   = 2,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int IN_ORDER  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [TAG_W-1:0]         disp_src1_tag,
  input  logic [TAG_W-1:0]         disp_src2_tag,
  input  logic                     disp_src1_rdy,
  input  logic                     disp_src2_rdy,
  input  logic [PAYLOAD_W-1:0]     disp_payload,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic                     flush,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [PAYLOAD_W-1:0]     iss_payload,
  output logic [TAG_W-1:0]         iss_src1_tag,
  output logic [TAG_W-1:0]         iss_src2_tag,
  output logic [$clog2(DEPTH):0]   free_cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]     valid_q, rdy1_q, rdy2_q;
  logic [TAG_W-1:0]     src1_q [DEPTH];
  logic [TAG_W-1:0]     src2_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  // older_q[i][j] set means entry i is older than entry j
  logic [DEPTH-1:0]     older_q [DEPTH];
  logic [CNT_W-1:0]     free_cnt_q;
  logic                 full_q, empty_q;
  logic                 hold_q;
  logic [IDX_W-1:0]     hold_idx_q;

  logic [DEPTH-1:0] wake1, wake2, issuable, older_iss, older_val;
  logic             disp_wake1, disp_wake2;
  logic             cand_found, oldest_found, sel_ok_ooo, sel_ok_ino, sel_ok;
  logic [IDX_W-1:0] cand_idx, oldest_idx, free_idx, sel_idx;
  logic             disp_fire, iss_fire;
  logic [CNT_W-1:0] free_cnt_next;

  always_comb begin
    disp_wake1 = 1'b0;
    disp_wake2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = 1'b0;
      wake2[i] = 1'b0;
      for (int p = 0; p < NUM_CDB; p++) begin
        if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == src1_q[i])) wake1[i] = 1'b1;
        if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == src2_q[i])) wake2[i] = 1'b1;
      end
    end
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == disp_src1_tag)) disp_wake1 = 1'b1;
      if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == disp_src2_tag)) disp_wake2 = 1'b1;
    end
  end

  assign issuable = valid_q & rdy1_q & rdy2_q;

  always_comb begin
    older_iss    = '0;
    older_val    = '0;
    cand_found   = 1'b0;
    cand_idx     = '0;
    oldest_found = 1'b0;
    oldest_idx   = '0;
    free_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (older_q[j][i]) begin
          older_iss[i] = older_iss[i] | issuable[j];
          older_val[i] = older_val[i] | valid_q[j];
        end
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (issuable[i] && !older_iss[i]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(i);
      end
      if (valid_q[i] && !older_val[i]) begin
        oldest_found = 1'b1;
        oldest_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // A stalled presentation is pinned so a late wakeup of an older entry cannot swap it out
  assign sel_ok_ooo = cand_found;
  assign sel_ok_ino = oldest_found && issuable[oldest_idx];
  assign sel_ok     = hold_q ? 1'b1 : ((IN_ORDER != 0) ? sel_ok_ino : sel_ok_ooo);
  assign sel_idx    = hold_q ? hold_idx_q : ((IN_ORDER != 0) ? oldest_idx : cand_idx);

  assign iss_valid    = sel_ok && !flush;
  assign iss_payload  = payload_q[sel_idx];
  assign iss_src1_tag = src1_q[sel_idx];
  assign iss_src2_tag = src2_q[sel_idx];

  assign disp_ready    = !full_q;
  assign disp_fire     = disp_valid && !full_q && !flush;
  assign iss_fire      = iss_valid && iss_ready;
  assign free_cnt_next = free_cnt_q - CNT_W'(disp_fire) + CNT_W'(iss_fire);

  assign free_cnt = free_cnt_q;
  assign full     = full_q;
  assign empty    = empty_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      free_cnt_q <= CNT_W'(DEPTH);
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      free_cnt_q <= CNT_W'(DEPTH);
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      hold_q     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake1[i]) rdy1_q[i] <= 1'b1;
        if (wake2[i]) rdy2_q[i] <= 1'b1;
      end
      if (iss_fire) valid_q[sel_idx] <= 1'b0;
      if (disp_fire) begin
        valid_q[free_idx]   <= 1'b1;
        rdy1_q[free_idx]    <= disp_src1_rdy | disp_wake1;
        rdy2_q[free_idx]    <= disp_src2_rdy | disp_wake2;
        src1_q[free_idx]    <= disp_src1_tag;
        src2_q[free_idx]    <= disp_src2_tag;
        payload_q[free_idx] <= disp_payload;
        older_q[free_idx]   <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (IDX_W'(j) != free_idx) older_q[j][free_idx] <= 1'b1;
        end
      end
      free_cnt_q <= free_cnt_next;
      full_q     <= (free_cnt_next == '0);
      empty_q    <= (free_cnt_next == CNT_W'(DEPTH));
      hold_q     <= iss_valid && !iss_ready;
      hold_idx_q <= sel_idx;
    end
  end

endmodule

// File: tb/tb_wakeup_select_queue.sv
// Directed bench for wakeup_select_queue: one out-of-order and one in-order instance share all inputs.
module tb_wakeup_select_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_src1_rdy, disp_src2_rdy;
  logic [5:0]  disp_src1_tag, disp_src2_tag;
  logic [63:0] disp_payload;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic        flush, iss_ready;

  logic        ooo_disp_ready, ooo_iss_valid, ooo_full, ooo_empty;
  logic [63:0] ooo_iss_payload;
  logic [5:0]  ooo_iss_src1_tag, ooo_iss_src2_tag;
  logic [4:0]  ooo_free_cnt;
  logic        ino_disp_ready, ino_iss_valid, ino_full, ino_empty;
  logic [63:0] ino_iss_payload;
  logic [5:0]  ino_iss_src1_tag, ino_iss_src2_tag;
  logic [4:0]  ino_free_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wakeup_select_queue #(.IN_ORDER(0)) u_ooo (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(ooo_disp_ready),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_payload(disp_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .flush(flush),
    .iss_valid(ooo_iss_valid), .iss_ready(iss_ready), .iss_payload(ooo_iss_payload),
    .iss_src1_tag(ooo_iss_src1_tag), .iss_src2_tag(ooo_iss_src2_tag),
    .free_cnt(ooo_free_cnt), .full(ooo_full), .empty(ooo_empty)
  );

  wakeup_select_queue #(.IN_ORDER(1)) u_ino (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(ino_disp_ready),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_payload(disp_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .flush(flush),
    .iss_valid(ino_iss_valid), .iss_ready(iss_ready), .iss_payload(ino_iss_payload),
    .iss_src1_tag(ino_iss_src1_tag), .iss_src2_tag(ino_iss_src2_tag),
    .free_cnt(ino_free_cnt), .full(ino_full), .empty(ino_empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    disp_valid = 1'b0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0; flush = 1'b0; iss_ready = 1'b0;
  endtask

  task automatic set_disp(input logic [5:0] t1, input logic r1, input logic [5:0] t2,
                          input logic r2, input logic [63:0] pl);
    disp_valid = 1'b1; disp_src1_tag = t1; disp_src1_rdy = r1;
    disp_src2_tag = t2; disp_src2_rdy = r2; disp_payload = pl;
  endtask

  task automatic pulse_reset;
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle_inputs();
    set_disp(6'd1, 1'b1, 6'd2, 1'b1, 64'h55);
    tick();
    tick();
    #1;
    checks++;
    if ({ooo_free_cnt, ooo_full, ooo_empty, ooo_disp_ready, ooo_iss_valid} !== {5'd16, 4'b0110}) begin
      errors++;
      $display("[TB] FAIL reset_ooo: got cnt=%0d f/e/r/v=%b%b%b%b expected cnt=16 f/e/r/v=0110",
               ooo_free_cnt, ooo_full, ooo_empty, ooo_disp_ready, ooo_iss_valid);
    end
    checks++;
    if ({ino_free_cnt, ino_full, ino_empty, ino_disp_ready, ino_iss_valid} !== {5'd16, 4'b0110}) begin
      errors++;
      $display("[TB] FAIL reset_ino: got cnt=%0d f/e/r/v=%b%b%b%b expected cnt=16 f/e/r/v=0110",
               ino_free_cnt, ino_full, ino_empty, ino_disp_ready, ino_iss_valid);
    end
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_ready_stream;
    pulse_reset();
    iss_ready = 1'b1;
    set_disp(6'd10, 1'b1, 6'd11, 1'b1, 64'h100);
    #1;
    checks++;
    if (ooo_iss_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_empty_valid: got %b expected 0", ooo_iss_valid);
    end
    tick();
    set_disp(6'd12, 1'b1, 6'd13, 1'b1, 64'h101);
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_iss_payload, ooo_iss_src1_tag, ooo_iss_src2_tag} !== {1'b1, 64'h100, 6'd10, 6'd11}) begin
      errors++;
      $display("[TB] FAIL stream_first: got v=%b pl=%0h t1=%0d t2=%0d expected v=1 pl=100 t1=10 t2=11",
               ooo_iss_valid, ooo_iss_payload, ooo_iss_src1_tag, ooo_iss_src2_tag);
    end
    tick();
    set_disp(6'd14, 1'b1, 6'd15, 1'b1, 64'h102);
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_iss_payload, ooo_free_cnt} !== {1'b1, 64'h101, 5'd15}) begin
      errors++;
      $display("[TB] FAIL stream_second: got v=%b pl=%0h cnt=%0d expected v=1 pl=101 cnt=15",
               ooo_iss_valid, ooo_iss_payload, ooo_free_cnt);
    end
    tick();
    disp_valid = 1'b0;
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_iss_payload, ooo_iss_src1_tag} !== {1'b1, 64'h102, 6'd14}) begin
      errors++;
      $display("[TB] FAIL stream_third: got v=%b pl=%0h t1=%0d expected v=1 pl=102 t1=14",
               ooo_iss_valid, ooo_iss_payload, ooo_iss_src1_tag);
    end
    tick();
    checks++;
    if ({ooo_iss_valid, ooo_empty, ooo_free_cnt} !== {1'b0, 1'b1, 5'd16}) begin
      errors++;
      $display("[TB] FAIL stream_drained: got v=%b e=%b cnt=%0d expected v=0 e=1 cnt=16",
               ooo_iss_valid, ooo_empty, ooo_free_cnt);
    end
  endtask

  task automatic test_wakeup_select;
    pulse_reset();
    set_disp(6'd5, 1'b0, 6'd7, 1'b1, 64'hA);
    tick();
    set_disp(6'd1, 1'b1, 6'd2, 1'b1, 64'hB);
    iss_ready = 1'b1;
    #1;
    checks++;
    if ({ooo_iss_valid, ino_iss_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wake_a_blocked: got ooo=%b ino=%b expected 00", ooo_iss_valid, ino_iss_valid);
    end
    tick();
    disp_valid = 1'b0;
    cdb_valid = 2'b10;
    cdb_tag = {6'd5, 6'd0};
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_iss_payload, ino_iss_valid} !== {1'b1, 64'hB, 1'b0}) begin
      errors++;
      $display("[TB] FAIL wake_b_first: got ooo v=%b pl=%0h ino v=%b expected ooo v=1 pl=b ino v=0",
               ooo_iss_valid, ooo_iss_payload, ino_iss_valid);
    end
    tick();
    cdb_valid = 2'b00;
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_iss_payload, ino_iss_valid, ino_iss_payload} !== {1'b1, 64'hA, 1'b1, 64'hA}) begin
      errors++;
      $display("[TB] FAIL wake_a_after_cdb: got ooo v=%b pl=%0h ino v=%b pl=%0h expected both v=1 pl=a",
               ooo_iss_valid, ooo_iss_payload, ino_iss_valid, ino_iss_payload);
    end
    tick();
    checks++;
    if ({ooo_iss_valid, ooo_empty, ino_iss_valid, ino_iss_payload} !== {1'b0, 1'b1, 1'b1, 64'hB}) begin
      errors++;
      $display("[TB] FAIL wake_tail: got ooo v=%b e=%b ino v=%b pl=%0h expected ooo v=0 e=1 ino v=1 pl=b",
               ooo_iss_valid, ooo_empty, ino_iss_valid, ino_iss_payload);
    end
    tick();
    checks++;
    if ({ino_iss_valid, ino_empty} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL wake_ino_drained: got v=%b e=%b expected v=0 e=1", ino_iss_valid, ino_empty);
    end
  endtask

  task automatic test_stall_hold;
    pulse_reset();
    set_disp(6'd4, 1'b0, 6'd3, 1'b1, 64'h31);
    tick();
    set_disp(6'd3, 1'b1, 6'd3, 1'b1, 64'h32);
    tick();
    disp_valid = 1'b0;
    cdb_valid = 2'b01;
    cdb_tag = {6'd0, 6'd4};
    tick();
    cdb_valid = 2'b00;
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_iss_payload} !== {1'b1, 64'h32}) begin
      errors++;
      $display("[TB] FAIL stall_hold: got v=%b pl=%0h expected v=1 pl=32", ooo_iss_valid, ooo_iss_payload);
    end
    iss_ready = 1'b1;
    tick();
    checks++;
    if ({ooo_iss_valid, ooo_iss_payload} !== {1'b1, 64'h31}) begin
      errors++;
      $display("[TB] FAIL stall_release: got v=%b pl=%0h expected v=1 pl=31", ooo_iss_valid, ooo_iss_payload);
    end
  endtask

  task automatic test_dispatch_bypass;
    pulse_reset();
    iss_ready = 1'b1;
    set_disp(6'd3, 1'b1, 6'd9, 1'b0, 64'hC0);
    cdb_valid = 2'b01;
    cdb_tag = {6'd0, 6'd9};
    tick();
    cdb_valid = 2'b00;
    set_disp(6'd3, 1'b1, 6'd9, 1'b0, 64'hC1);
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_iss_payload, ooo_iss_src2_tag} !== {1'b1, 64'hC0, 6'd9}) begin
      errors++;
      $display("[TB] FAIL bypass_issuable: got v=%b pl=%0h t2=%0d expected v=1 pl=c0 t2=9",
               ooo_iss_valid, ooo_iss_payload, ooo_iss_src2_tag);
    end
    tick();
    disp_valid = 1'b0;
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_free_cnt} !== {1'b0, 5'd15}) begin
      errors++;
      $display("[TB] FAIL bypass_no_false_wake: got v=%b cnt=%0d expected v=0 cnt=15",
               ooo_iss_valid, ooo_free_cnt);
    end
  endtask

  task automatic test_full;
    logic [63:0] exp_pl;
    pulse_reset();
    for (int k = 0; k < 16; k++) begin
      set_disp(6'd1, 1'b1, 6'd1, 1'b1, 64'(k));
      tick();
    end
    #1;
    checks++;
    if ({ooo_full, ooo_disp_ready, ooo_free_cnt} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("[TB] FAIL full_flags: got f=%b r=%b cnt=%0d expected f=1 r=0 cnt=0",
               ooo_full, ooo_disp_ready, ooo_free_cnt);
    end
    set_disp(6'd1, 1'b1, 6'd1, 1'b1, 64'h99);
    iss_ready = 1'b1;
    tick();
    checks++;
    if ({ooo_free_cnt, ooo_full, ooo_disp_ready} !== {5'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL full_issue_only: got cnt=%0d f=%b r=%b expected cnt=1 f=0 r=1",
               ooo_free_cnt, ooo_full, ooo_disp_ready);
    end
    iss_ready = 1'b0;
    tick();
    disp_valid = 1'b0;
    checks++;
    if ({ooo_free_cnt, ooo_full} !== {5'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL full_refill: got cnt=%0d f=%b expected cnt=0 f=1", ooo_free_cnt, ooo_full);
    end
    iss_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1;
      exp_pl = (k == 16) ? 64'h99 : 64'(k);
      checks++;
      if ({ooo_iss_valid, ooo_iss_payload} !== {1'b1, exp_pl}) begin
        errors++;
        $display("[TB] FAIL full_drain_order[%0d]: got v=%b pl=%0h expected v=1 pl=%0h",
                 k, ooo_iss_valid, ooo_iss_payload, exp_pl);
      end
      tick();
    end
  endtask

  task automatic test_flush;
    pulse_reset();
    for (int k = 0; k < 10; k++) begin
      set_disp(6'd2, 1'b1, 6'd2, 1'b1, 64'h200 + 64'(k));
      tick();
    end
    set_disp(6'd2, 1'b1, 6'd2, 1'b1, 64'h77);
    flush = 1'b1;
    iss_ready = 1'b1;
    #1;
    checks++;
    if ({ooo_free_cnt, ooo_iss_valid, ino_iss_valid} !== {5'd6, 2'b00}) begin
      errors++;
      $display("[TB] FAIL flush_cycle: got cnt=%0d ooo v=%b ino v=%b expected cnt=6 v=0 v=0",
               ooo_free_cnt, ooo_iss_valid, ino_iss_valid);
    end
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    #1;
    checks++;
    if ({ooo_empty, ooo_free_cnt, ooo_iss_valid} !== {1'b1, 5'd16, 1'b0}) begin
      errors++;
      $display("[TB] FAIL flush_after: got e=%b cnt=%0d v=%b expected e=1 cnt=16 v=0",
               ooo_empty, ooo_free_cnt, ooo_iss_valid);
    end
  endtask

  task automatic test_reset_mid;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      set_disp(6'd12, 1'b0, 6'd1, 1'b1, 64'h300 + 64'(k));
      tick();
    end
    rst = 1'b0;
    set_disp(6'd1, 1'b1, 6'd1, 1'b1, 64'h3F);
    cdb_valid = 2'b01;
    cdb_tag = {6'd0, 6'd12};
    iss_ready = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b1;
    idle_inputs();
    iss_ready = 1'b1;
    #1;
    checks++;
    if ({ooo_free_cnt, ooo_full, ooo_empty, ooo_disp_ready, ooo_iss_valid} !== {5'd16, 4'b0110}) begin
      errors++;
      $display("[TB] FAIL midreset_state: got cnt=%0d f/e/r/v=%b%b%b%b expected cnt=16 f/e/r/v=0110",
               ooo_free_cnt, ooo_full, ooo_empty, ooo_disp_ready, ooo_iss_valid);
    end
    set_disp(6'd12, 1'b0, 6'd1, 1'b1, 64'h3A);
    tick();
    disp_valid = 1'b0;
    #1;
    checks++;
    if ({ooo_iss_valid, ooo_free_cnt} !== {1'b0, 5'd15}) begin
      errors++;
      $display("[TB] FAIL midreset_stale_tag: got v=%b cnt=%0d expected v=0 cnt=15",
               ooo_iss_valid, ooo_free_cnt);
    end
    tick();
    checks++;
    if (ooo_iss_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_stays_blocked: got v=%b expected 0", ooo_iss_valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_ready_stream();
    test_wakeup_select();
    test_stall_hold();
    test_dispatch_bypass();
    test_full();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
